// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: CPU-side command FIFO and word-pair serializer feeding the
// GPU text engine's cpuline input. Each queued {cmd, param} pair is replayed
// as cmd (A phase), param (B phase), then an EXEC cycle for nonzero commands.
// The FSM tracks the GPU's A/B phase exactly; CMD and IDLE0 always fall in
// the A phase.
// Optional feature: define GPU_CMD_FILTER_EN to reject writes whose command
// lies outside 0x00C0..0x00C6. Rejected writes pulse drop_err and never set
// overflow.
// Handshake: a write is accepted on a rising edge when wr_en is high, the
// command passes the filter and full (pre-edge) is low; there is no
// backpressure other than full, and a write while full is dropped.
module gpu_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [15:0]   wr_cmd,
    input  logic [15:0]   wr_param,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          overflow,
    output logic          drop_err,
    output logic [15:0]   cpuline,
    output logic [2:0]    state_dbg
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE0 = 3'd0,
        S_IDLE1 = 3'd1,
        S_CMD   = 3'd2,
        S_PARAM = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic [15:0]   cur_cmd, cur_param;
    logic [15:0]   cpuline_nxt;
    logic [31:0]   head;
    logic          cmd_ok;
    logic          wr_acc;
    logic          pop;
    logic          decide;

    assign full      = (count == LW'(DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign busy      = (state == S_CMD) || (state == S_PARAM) || (state == S_EXEC);
    assign state_dbg = state;
    assign head      = mem[rd_ptr];

`ifdef GPU_CMD_FILTER_EN
    assign cmd_ok = (wr_cmd >= 16'h00C0) && (wr_cmd <= 16'h00C6);

    // One-cycle pulse for each write rejected by the command filter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            drop_err <= 1'b0;
        end else begin
            drop_err <= wr_en && !cmd_ok;
        end
    end
`else
    assign cmd_ok   = 1'b1;
    assign drop_err = 1'b0;
`endif

    // Filter is checked first, so a filtered write never counts as overflow.
    assign wr_acc = wr_en && cmd_ok && !full;

    // Next-state and next cpuline word; the head is popped only on entry to CMD.
    always_comb begin
        state_nxt   = state;
        cpuline_nxt = 16'h0000;
        pop         = 1'b0;
        decide      = 1'b0;
        case (state)
            S_IDLE0: state_nxt = S_IDLE1;
            S_IDLE1: decide = 1'b1;
            S_CMD: begin
                state_nxt   = S_PARAM;
                cpuline_nxt = cur_param;
            end
            S_PARAM: begin
                if (cur_cmd != 16'h0000) begin
                    state_nxt = S_EXEC;
                end else begin
                    decide = 1'b1;
                end
            end
            S_EXEC:  decide = 1'b1;
            default: state_nxt = S_IDLE0;
        endcase
        if (decide) begin
            if (!empty) begin
                state_nxt   = S_CMD;
                pop         = 1'b1;
                cpuline_nxt = head[31:16];
            end else begin
                state_nxt = S_IDLE0;
            end
        end
    end

    // FSM, output word and current-pair registers; clr zeroes cpuline at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE1;
            cpuline   <= 16'h0000;
            cur_cmd   <= 16'h0000;
            cur_param <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cpuline <= cpuline_nxt;
            if (pop) begin
                cur_cmd   <= head[31:16];
                cur_param <= head[15:0];
            end
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (wr_en && cmd_ok && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {wr_cmd, wr_param};
        end
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb_gpu_cmd_queue: randomized bench for gpu_cmd_queue. A GPU-phase reference
// model (A/B/EXEC phases over a queue of pairs) predicts busy, level and
// flags per cycle; a scoreboard queue of accepted pairs is checked against
// the words replayed on cpuline.
module tb_gpu_cmd_queue;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef GPU_CMD_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam int PH_A = 0;
  localparam int PH_B = 1;
  localparam int PH_X = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic wr_en = 1'b0;
  logic [15:0] wr_cmd = 16'h0;
  logic [15:0] wr_param = 16'h0;
  logic full, empty, busy, overflow, drop_err;
  logic [LW-1:0] level;
  logic [15:0] cpuline;
  logic [2:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_q[$];
  int m_phase;
  bit m_busy;
  logic [15:0] m_cmd;
  bit m_ovf;
  bit m_drop;

  gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_param(wr_param),
    .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow),
    .drop_err(drop_err), .cpuline(cpuline), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit cmd_ok(input logic [15:0] c);
    return !FILTER || ((c >= 16'h00C0) && (c <= 16'h00C6));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: GPU phases and a queue of pending pairs
  task automatic model_reset();
    m_q.delete();
    m_phase = PH_B;
    m_busy = 1'b0;
    m_cmd = 16'h0;
    m_ovf = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_step();
    bit full_pre, empty_pre, ok, dec;
    logic [31:0] pr;
    full_pre = (m_q.size() == DEPTH);
    empty_pre = (m_q.size() == 0);
    ok = cmd_ok(wr_cmd);
    m_drop = wr_en && !ok;
    if (wr_en && ok && full_pre) m_ovf = 1'b1;
    dec = 1'b0;
    case (m_phase)
      PH_A: m_phase = PH_B;
      PH_B: if (m_busy && m_cmd != 16'h0) m_phase = PH_X; else dec = 1'b1;
      default: dec = 1'b1;
    endcase
    if (dec) begin
      m_phase = PH_A;
      if (!empty_pre) begin
        pr = m_q.pop_front();
        m_cmd = pr[31:16];
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
    if (wr_en && ok && !full_pre) m_q.push_back({wr_cmd, wr_param});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (clr) model_reset();
      else model_step();
    end
  end

  // per-cycle checks of timing and flags against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!clr) begin
        chk("busy", busy, m_busy);
        chk("level", level, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("drop_err", drop_err, m_drop);
        if (!m_busy) chk("idle_cpuline", cpuline, 32'h0);
      end
    end
  end

  // scoreboard monitor: each busy burst must replay the next accepted pair
  initial begin
    int stage;
    logic [31:0] pair;
    stage = 0;
    pair = '0;
    forever begin
      @(negedge clk);
      if (clr) begin
        stage = 0;
      end else begin
        case (stage)
          0: if (busy) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_pair: got cmd %0h expected no pair", cpuline);
            end else begin
              pair = exp_q.pop_front();
              chk("pair_cmd", cpuline, pair[31:16]);
              stage = 1;
            end
          end
          1: begin
            chk("param_busy", busy, 1);
            chk("pair_param", cpuline, pair[15:0]);
            stage = (pair[31:16] != 16'h0) ? 2 : 0;
          end
          default: begin
            chk("exec_busy", busy, 1);
            chk("exec_cpuline", cpuline, 32'h0);
            stage = 0;
          end
        endcase
      end
    end
  end

  // driver tasks
  task automatic drive(input bit en, input logic [15:0] c, input logic [15:0] p);
    @(negedge clk);
    wr_en = en;
    wr_cmd = c;
    wr_param = p;
    if (en && cmd_ok(c) && m_q.size() < DEPTH) exp_q.push_back({c, p});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0);
  endtask

  function automatic logic [15:0] rand_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 16'h00C0 + 16'(r);
    else if (r == 7) return 16'h0000;
    else return 16'($urandom_range(0, 65535));
  endfunction

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b1, rand_cmd(), 16'($urandom_range(0, 65535)));
      else drive(1'b0, 16'h0, 16'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpuline"}, cpuline, 32'h0);
    chk({tag, "_level"}, level, 32'h0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_err"}, drop_err, 0);
  endtask

  task automatic clr_during_cmd();
    bit found;
    idle(4 * DEPTH + 10);
    drive(1'b1, 16'h00C2, 16'h0055);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (busy) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL clr_wait: busy never rose, expected a CMD cycle");
    end else begin
      #1 clr = 1'b1;
      exp_q.delete();
      #1 check_reset_outputs("clr_async");
    end
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  // main stimulus sequence
  initial begin
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 clr = 1'b0;

    idle(10);
    drive(1'b1, 16'h00C1, 16'h0041);
    idle(8);
    drive(1'b1, 16'h00C5, 16'h0000);
    drive(1'b1, 16'h00C1, 16'h0048);
    drive(1'b1, 16'h00C1, 16'h0049);
    drive(1'b1, 16'h00C6, 16'h0000);
    idle(16);
    for (int i = 0; i < 16; i++)
      drive(1'b1, 16'h00C0 + 16'($urandom_range(0, 6)), 16'(i));
    idle(3 * DEPTH + 10);
    drive(1'b1, 16'h0000, 16'h1234);
    drive(1'b1, 16'h00C7, 16'h5678);
    idle(10);
    random_traffic(400);

    clr_during_cmd();
    drive(1'b1, 16'h00C3, 16'h0077);
    drive(1'b1, 16'h0000, 16'h0011);
    random_traffic(200);

    for (int i = 0; i < 100 && (m_q.size() != 0 || m_busy); i++) idle(1);
    idle(4);
    chk("drained_exp_q", exp_q.size(), 0);
    chk("drained_level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
